// File: rtl/memory_compression_pkg.sv
// Shared types and compression helpers for the lossy compressed memory bank and
// any other store that keeps only the upper bits of a word.
package memory_compression_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic CMP_TRUNC = 1'b0;
  localparam logic CMP_ROUND = 1'b1;

  // Widest uncompressed word the helpers handle; callers zero-extend into this.
  localparam int unsigned MAX_W = 64;

  // Keeps the upper cbw bits of a bw-bit word. Round mode adds the first dropped bit,
  // saturating at all ones instead of wrapping to zero.
  function automatic logic [MAX_W-1:0] compress(input logic [MAX_W-1:0] data,
                                                input logic             mode,
                                                input int unsigned      bw,
                                                input int unsigned      cbw);
    logic [MAX_W-1:0] upper;
    logic [MAX_W-1:0] ones;
    logic             rnd;
    ones  = (MAX_W'(1) << cbw) - MAX_W'(1);
    upper = (data >> (bw - cbw)) & ones;
    rnd   = ((data >> (bw - cbw - 1)) & MAX_W'(1)) != '0;
    if (mode == CMP_ROUND && rnd && upper != ones) begin
      upper = upper + MAX_W'(1);
    end
    return upper;
  endfunction

  // Re-expands a stored word to bw bits with the dropped low bits as zeros.
  function automatic logic [MAX_W-1:0] decompress(input logic [MAX_W-1:0] word,
                                                  input int unsigned      bw,
                                                  input int unsigned      cbw);
    return word << (bw - cbw);
  endfunction

endpackage

// File: rtl/memory_compression_encoder.sv
// Combinational truncate / round-and-saturate compressor, BW bits down to COMPRESS_BW.
module memory_compression_encoder
  import memory_compression_pkg::*;
#(
  parameter int unsigned BW          = 16,
  parameter int unsigned COMPRESS_BW = 8
) (
  input  logic [BW-1:0]          data,
  input  logic                   mode,
  output logic [COMPRESS_BW-1:0] word
);

  always_comb begin
    word = COMPRESS_BW'(compress(MAX_W'(data), mode, BW, COMPRESS_BW));
  end

endmodule

// File: rtl/memory_compression_bank.sv
// Lossy scratch store: compressed array with valid bits, clear sweep and 2-stage read.
// Optional per-entry even parity and rd_perr output: MEMORY_COMPRESSION_BANK_PARITY_EN.
module memory_compression_bank
  import memory_compression_pkg::*;
#(
  parameter int unsigned BW          = 16,
  parameter int unsigned COMPRESS_BW = 8,
  parameter int unsigned MW          = 16,
  parameter int unsigned AW          = $clog2(MW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data,
  input  logic          wr_mode,
  output logic          wr_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [BW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_hit,
  output logic          busy
`ifdef MEMORY_COMPRESSION_BANK_PARITY_EN
  ,
  output logic          rd_perr
`endif
);

  state_e                 state;
  logic [AW-1:0]          sweep_cnt;
  logic [COMPRESS_BW-1:0] mem [MW];
  logic [MW-1:0]          vld;
  logic [COMPRESS_BW-1:0] enc_word;
  logic                   wr_fire;
  logic                   rd_fire;

  logic                   s1_valid;
  logic [COMPRESS_BW-1:0] s1_word;
  logic                   s1_hit;

  assign wr_fire = (state == READY) && wr_en;
  assign rd_fire = (state == READY) && rd_en;

  memory_compression_encoder #(
    .BW          (BW),
    .COMPRESS_BW (COMPRESS_BW)
  ) u_encoder (
    .data (wr_data),
    .mode (wr_mode),
    .word (enc_word)
  );

  // wr_ready and busy are registered alongside state so they mirror it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      wr_ready  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          if (sweep_cnt == AW'(MW - 1)) begin
            sweep_cnt <= '0;
            state     <= READY;
            wr_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + AW'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            state    <= CLEAR;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

  // The array is never reset; the sweep is the only way entries return to zero.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[sweep_cnt] <= '0;
      vld[sweep_cnt] <= 1'b0;
    end else if (wr_fire) begin
      mem[wr_addr] <= enc_word;
      vld[wr_addr] <= 1'b1;
    end
  end

  // Stage 1 samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_hit   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_hit   <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_word <= mem[rd_addr];
        s1_hit  <= vld[rd_addr];
      end
      rd_valid <= s1_valid;
      if (s1_valid) begin
        rd_data <= BW'(decompress(MAX_W'(s1_word), BW, COMPRESS_BW));
        rd_hit  <= s1_hit;
      end
    end
  end

`ifdef MEMORY_COMPRESSION_BANK_PARITY_EN
  logic [MW-1:0] par;
  logic          s1_par;

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par[sweep_cnt] <= 1'b0;
    end else if (wr_fire) begin
      par[wr_addr] <= ^enc_word;
    end
  end

  // Unwritten entries hold parity 0 over a zero word, so only written hits are flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_par  <= 1'b0;
      rd_perr <= 1'b0;
    end else begin
      if (rd_fire) begin
        s1_par <= par[rd_addr];
      end
      rd_perr <= s1_valid && s1_hit && ((^s1_word) != s1_par);
    end
  end
`endif

endmodule

// File: tb/tb_memory_compression_bank.sv
// Randomized self-checking bench for memory_compression_bank against a behavioural model.
module tb_memory_compression_bank;

  localparam int MW = 16;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_mode;
  logic        wr_ready;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_hit;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  // Model: contents kept as decompressed 16-bit values; a clear is applied as a whole
  // when the sweep finishes, since nothing can observe the array while it is sweeping.
  logic [15:0] mem_m [MW];
  bit          vld_m [MW];
  bit          ready_m;
  int          sweep_left;
  bit          p1_v;
  logic [15:0] p1_d;
  bit          p1_h;
  bit          exp_valid;
  logic [15:0] exp_data;
  bit          exp_hit;

  memory_compression_bank dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mode  (wr_mode),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_hit   (rd_hit),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] compress_m(input logic [15:0] d, input bit m);
    int u;
    u = int'(d) / 256;
    if (m && (int'(d) % 256) >= 128 && u < 255) u = u + 1;
    return 16'(u * 256);
  endfunction

  task automatic model_reset();
    ready_m    = 0;
    sweep_left = MW;
    p1_v       = 0;
    exp_valid  = 0;
    exp_data   = '0;
    exp_hit    = 0;
  endtask

  // Advances the model over the next rising edge using the inputs now being driven.
  task automatic model_edge();
    exp_valid = p1_v;
    if (p1_v) begin
      exp_data = p1_d;
      exp_hit  = p1_h;
    end
    p1_v = ready_m && rd_en;
    if (p1_v) begin
      p1_d = mem_m[rd_addr];
      p1_h = vld_m[rd_addr];
    end
    if (ready_m && wr_en) begin
      mem_m[wr_addr] = compress_m(wr_data, wr_mode);
      vld_m[wr_addr] = 1;
    end
    if (ready_m) begin
      if (clr_req) begin
        ready_m    = 0;
        sweep_left = MW;
      end
    end else begin
      sweep_left--;
      if (sweep_left == 0) begin
        ready_m = 1;
        for (int i = 0; i < MW; i++) begin
          mem_m[i] = '0;
          vld_m[i] = 0;
        end
      end
    end
  endtask

  // Compare process: every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    check("wr_ready", wr_ready, ready_m);
    check("busy", busy, !ready_m);
    check("rd_valid", rd_valid, exp_valid);
    check("rd_data", rd_data, exp_data);
    check("rd_hit", rd_hit, exp_hit);
  end

  task automatic set_idle();
    wr_en   = 0;
    wr_addr = '0;
    wr_data = '0;
    wr_mode = 0;
    rd_en   = 0;
    rd_addr = '0;
    clr_req = 0;
  endtask

  task automatic step(input bit we, input int wa, input logic [15:0] wd, input bit wm,
                      input bit re, input int ra, input bit cr);
    @(negedge clk);
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_data = wd;
    wr_mode = wm;
    rd_en   = re;
    rd_addr = 4'(ra);
    clr_req = cr;
    model_edge();
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_hit", rd_hit, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    model_edge();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 40) begin
      idle();
      n++;
    end
  endtask

  // Directed read with literal expectations and a latency check.
  task automatic read_lit(input int a, input logic [15:0] d, input bit h);
    step(0, 0, 16'h0, 0, 1, a, 0);
    @(negedge clk);
    check("lat1_valid", rd_valid, 0);
    set_idle();
    model_edge();
    @(negedge clk);
    check("lit_valid", rd_valid, 1);
    check("lit_data", rd_data, d);
    check("lit_hit", rd_hit, h);
    set_idle();
    model_edge();
  endtask

  initial begin
    int n;
    for (int i = 0; i < MW; i++) begin
      mem_m[i] = '0;
      vld_m[i] = 0;
    end
    model_reset();
    set_idle();
    rst = 1;
    #2;
    apply_reset();
    wait_ready(n);
    check("busy_len", n, 16);
    for (int a = 0; a < MW; a++) read_lit(a, 16'h0000, 0);

    step(1, 3, 16'hAB7F, 0, 0, 0, 0);
    read_lit(3, 16'hAB00, 1);
    step(1, 3, 16'hAB7F, 1, 0, 0, 0);
    read_lit(3, 16'hAB00, 1);
    step(1, 3, 16'hAB80, 1, 0, 0, 0);
    read_lit(3, 16'hAC00, 1);
    step(1, 4, 16'hFFC0, 1, 0, 0, 0);
    read_lit(4, 16'hFF00, 1);

    // Read-before-write on the same address.
    step(1, 5, 16'h3400, 0, 0, 0, 0);
    step(1, 5, 16'h1200, 0, 1, 5, 0);
    idle();
    @(negedge clk);
    check("rbw_data", rd_data, 16'h3400);
    set_idle();
    model_edge();
    read_lit(5, 16'h1200, 1);

    // Read in flight across a clear; write during the sweep is dropped.
    step(1, 7, 16'h5500, 0, 0, 0, 0);
    step(0, 0, 16'h0, 0, 1, 7, 1);
    step(1, 7, 16'h7700, 0, 0, 0, 0);
    @(negedge clk);
    check("clr_inflight_data", rd_data, 16'h5500);
    check("clr_inflight_hit", rd_hit, 1);
    set_idle();
    model_edge();
    wait_ready(n);
    check("clr_ready_timeout", n < 40, 1);
    read_lit(7, 16'h0000, 0);

    // Reset mid-sweep at counter 9.
    step(0, 0, 16'h0, 0, 0, 0, 1);
    repeat (9) idle();
    @(negedge clk);
    apply_reset();
    wait_ready(n);
    check("busy_len_after_rst", n, 16);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] wd;
      wd = 16'($urandom);
      if ($urandom_range(0, 7) == 0) wd[15:8] = 8'hFF;
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), wd,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)), $urandom_range(0, 63) == 0);
    end
    idle();
    idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_compression_bank.md
Name: memory_compression_bank

Overview:
- Parametrised successor to the fixed 16x16 truncating compressed memory.
- Stores only the upper COMPRESS_BW bits of each word. Write-side compression mode is selectable per write: truncate, or round-to-nearest with saturation.
- Adds per-entry valid bits, a handshaked clear sweep (the array itself is not reset), and a 2-stage registered read pipeline with a valid/hit indication.
- Sits between datapath producers and consumers as a small lossy scratch store.

Parameters:
- BW, 16, uncompressed data width; must be > COMPRESS_BW.
- COMPRESS_BW, 8, stored width per entry; must be >= 1.
- MW, 16, number of entries; must be >= 2.
- AW, $clog2(MW), address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- clr_req  in  1  pulse; requests a clear sweep. Honoured only in READY.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  BW  uncompressed write data.
- wr_mode  in  1  0 = truncate, 1 = round+saturate.
- wr_ready  out  1  high when writes are accepted (READY state).
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_data  out  BW  decompressed read data.
- rd_valid  out  1  one-cycle strobe; rd_data is valid.
- rd_hit  out  1  qualifies rd_valid; entry has been written since the last clear.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst low, async):
  - state=CLEAR, sweep counter=0.
  - rd_data=0, rd_valid=0, rd_hit=0, wr_ready=0, busy=1.
  - Read pipeline valid flags cleared.
  - Array and valid bits are NOT reset directly; the sweep clears them.
- FSM, two states:
  - CLEAR: each cycle writes data=0 and valid=0 at counter, then increments the counter. After entry MW-1: counter returns to 0, state goes to READY. Takes exactly MW cycles.
  - READY: clr_req=1 → CLEAR on the next edge. clr_req while in CLEAR is ignored.
- Write: accepted when state==READY && wr_en.
  - stored <= compress(wr_data, wr_mode); valid[wr_addr] <= 1.
  - Writes issued in CLEAR are dropped silently (wr_ready=0).
  - A write and clr_req in the same READY cycle: the write is committed, then the sweep starts.
- Compression:
  - Truncate: wr_data[BW-1 -: COMPRESS_BW].
  - Round: upper + wr_data[BW-COMPRESS_BW-1]. If upper is all ones and the round bit is 1, the result saturates to all ones (no wrap).
- Read: accepted when state==READY && rd_en; ignored in CLEAR.
  - Stage 1 registers the array word, valid bit and a valid flag.
  - Stage 2 registers rd_data = {word, (BW-COMPRESS_BW) zeros}, rd_hit, rd_valid.
  - Latency: 2 cycles from rd_en to rd_valid. Fully pipelined, one read per cycle.
  - rd_data and rd_hit hold their values when rd_valid=0.
  - An unwritten entry returns rd_data=0, rd_hit=0.
- Same-address read and write in the same cycle: read-before-write. The read returns the old contents.
- Reads already in the pipeline when a sweep starts still complete and return pre-clear data.
- Reset mid-sweep: the sweep restarts from 0.

Optional Feature:
- Macro MEMORY_COMPRESSION_BANK_PARITY_EN.
- When defined:
  - Each entry stores an extra even-parity bit over the stored word.
  - Adds output port rd_perr (1 bit, reset 0), aligned with rd_valid. It is high if the recomputed parity mismatches on a valid read of a written entry.
  - Sweep writes parity 0.
- When undefined: no parity storage and no rd_perr port.

Decomposition:
- Package memory_compression_pkg holds:
  - state enum (CLEAR, READY);
  - mode constants (CMP_TRUNC=0, CMP_ROUND=1);
  - compress function (data, mode) → COMPRESS_BW;
  - decompress function.
- One natural sub-module: memory_compression_encoder, the combinational truncate/round/saturate unit. It is reusable by other lossy stores.
- The top holds the FSM, the array and the read pipeline.

Test Plan (BW=16, COMPRESS_BW=8, MW=16):
- Release reset → busy=1, wr_ready=0 for exactly 16 cycles, then busy=0, wr_ready=1. Reads of all 16 addresses → rd_data=0x0000, rd_hit=0.
- Write addr 3 = 0xAB7F with mode 0 → read returns 0xAB00, rd_hit=1, rd_valid exactly 2 cycles after rd_en. Same data with mode 1 → 0xAB00; data 0xAB80 with mode 1 → 0xAC00.
- Mode 1, write 0xFFC0 → 0xFF00 (saturated, not 0x0000).
- Same cycle: write addr 5 = 0x1200 and read addr 5, whose previous contents are 0x3400 → read returns 0x3400; the next read returns 0x1200.
- Write addr 7 = 0x5500, then pulse clr_req with a read of addr 7 issued the same cycle → read returns 0x5500/hit=1. A write during CLEAR is dropped. After 16 cycles, a read of addr 7 → 0x0000/hit=0.
- Assert rst low mid-sweep at counter=9 → outputs go to reset values immediately. After release, busy stays high for a full 16 cycles.
